// File: rtl/process_images_mac_pipe.sv
// process_images_mac_pipe: pipelined signed/unsigned multiplier with optional running-sum accumulator.
module process_images_mac_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 30,
   parameter int din1_WIDTH = 30,
   parameter int dout_WIDTH = 60,
   parameter int SIGNED     = 0,
   parameter int ACC_EN     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic                  acc_clr,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  out_valid
);
   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam int XW = dout_WIDTH > PW ? dout_WIDTH : PW;

   if (NUM_STAGE < 2 || NUM_STAGE > 8) begin : g_bad_stage
      $error("NUM_STAGE must be in 2..8");
   end
   if (ACC_EN == 0 && dout_WIDTH < PW) begin : g_bad_width
      $error("dout_WIDTH too narrow for full product");
   end

   logic [din0_WIDTH-1:0] r_a;
   logic [din1_WIDTH-1:0] r_b;
   logic [NUM_STAGE-2:0]  r_v, r_c;
   logic [XW-1:0]         w_a, w_b, w_ext;
   logic [dout_WIDTH-1:0] w_prod, w_fp, w_base;
   logic                  w_fv, w_fc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
         r_v <= '0;
         r_c <= '0;
      end else if (ce) begin
         r_a    <= din0;
         r_b    <= din1;
         r_v[0] <= in_valid;
         r_c[0] <= acc_clr;
         for (int i = 1; i < NUM_STAGE-1; i++) begin
            r_v[i] <= r_v[i-1];
            r_c[i] <= r_c[i-1];
         end
      end
   end

   // Operands are widened to at least the full product width, so the low bits are exact in both modes.
   assign w_a    = {{(XW-din0_WIDTH){SIGNED != 0 && r_a[din0_WIDTH-1]}}, r_a};
   assign w_b    = {{(XW-din1_WIDTH){SIGNED != 0 && r_b[din1_WIDTH-1]}}, r_b};
   assign w_ext  = w_a * w_b;
   assign w_prod = w_ext[dout_WIDTH-1:0];

   if (XW > dout_WIDTH) begin : g_trunc
      logic w_unused;
      assign w_unused = ^w_ext[XW-1:dout_WIDTH];
   end

   if (NUM_STAGE == 2) begin : g_direct
      assign w_fp = w_prod;
   end else begin : g_pipe
      logic [dout_WIDTH-1:0] r_p [NUM_STAGE-2];
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < NUM_STAGE-2; i++) r_p[i] <= '0;
         end else if (ce) begin
            r_p[0] <= w_prod;
            for (int i = 1; i < NUM_STAGE-2; i++) r_p[i] <= r_p[i-1];
         end
      end
      assign w_fp = r_p[NUM_STAGE-3];
   end

   assign w_fv   = r_v[NUM_STAGE-2];
   assign w_fc   = r_c[NUM_STAGE-2];
   assign w_base = (ACC_EN != 0 && !w_fc) ? dout : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         dout      <= '0;
         out_valid <= 1'b0;
      end else if (ce) begin
         out_valid <= w_fv;
         if (w_fv) dout <= w_base + w_fp;
      end
   end
endmodule
